// File: rtl/hough_peak_pkg.sv
// Shared types for the Hough peak selector: FSM state encoding and the
// top-K peak table entry.
package hough_peak_pkg;

  localparam int VOTE_BITS  = 16;
  localparam int FIELD_BITS = 16;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [VOTE_BITS-1:0]  votes;
    logic [FIELD_BITS-1:0] rho;
    logic [FIELD_BITS-1:0] theta;
    logic                  valid;
  } peak_entry_t;

  function automatic peak_entry_t make_entry(
    input logic [VOTE_BITS-1:0]  votes,
    input logic [FIELD_BITS-1:0] rho,
    input logic [FIELD_BITS-1:0] theta
  );
    peak_entry_t e;
    e.votes = votes;
    e.rho   = rho;
    e.theta = theta;
    e.valid = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/hough_peak_select_table.sv
// Sorted top-K peak table: single-cycle sorted insertion, valid clear and
// read-by-index port.
module hough_peak_table
  import hough_peak_pkg::*;
#(
  parameter int          NUM_PEAKS  = 4,
  parameter logic [15:0] THRESHOLD  = 16'd32,
  parameter int          RHO_BITS   = 10,
  parameter int          THETA_BITS = 8,
  parameter int          IDX_W      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  ins_en,
  input  logic [15:0]           ins_votes,
  input  logic [RHO_BITS-1:0]   ins_rho,
  input  logic [THETA_BITS-1:0] ins_theta,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [15:0]           rd_votes,
  output logic [RHO_BITS-1:0]   rd_rho,
  output logic [THETA_BITS-1:0] rd_theta,
  output logic                  rd_valid,
  output logic [NUM_PEAKS-1:0]  valid_vec
);

  peak_entry_t              slot_r      [NUM_PEAKS];
  peak_entry_t              slot_next_s [NUM_PEAKS];
  peak_entry_t              new_entry_s;
  logic [NUM_PEAKS-1:0]     gt_s;
  logic                     do_ins_s;

  // Insertion position is the first slot the newcomer strictly beats; strict
  // compare keeps older equal-vote entries ranked above the newcomer.
  always_comb begin
    gt_s        = '0;
    new_entry_s = make_entry(ins_votes, FIELD_BITS'(ins_rho), FIELD_BITS'(ins_theta));
    do_ins_s    = ins_en && (ins_votes >= THRESHOLD);
    for (int i = 0; i < NUM_PEAKS; i++) begin
      gt_s[i] = !slot_r[i].valid || (ins_votes > slot_r[i].votes);
    end
    if (do_ins_s && gt_s[0]) begin
      slot_next_s[0] = new_entry_s;
    end else begin
      slot_next_s[0] = slot_r[0];
    end
    for (int i = 1; i < NUM_PEAKS; i++) begin
      if (do_ins_s && gt_s[i] && gt_s[i-1]) begin
        slot_next_s[i] = slot_r[i-1];
      end else if (do_ins_s && gt_s[i]) begin
        slot_next_s[i] = new_entry_s;
      end else begin
        slot_next_s[i] = slot_r[i];
      end
    end
  end

  // Table storage: reset wipes everything, clear only drops valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PEAKS; i++) slot_r[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_PEAKS; i++) slot_r[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PEAKS; i++) slot_r[i] <= slot_next_s[i];
    end
  end

  // Read port and valid vector.
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_PEAKS; i++) valid_vec[i] = slot_r[i].valid;
    rd_votes = slot_r[rd_idx].votes;
    rd_rho   = slot_r[rd_idx].rho[RHO_BITS-1:0];
    rd_theta = slot_r[rd_idx].theta[THETA_BITS-1:0];
    rd_valid = slot_r[rd_idx].valid;
  end

endmodule

// File: rtl/hough_peak_select.sv
// Scans one Hough accumulator frame, keeps the top-K peaks above threshold,
// then streams them out strongest first.
module hough_peak_select
  import hough_peak_pkg::*;
#(
  parameter int          THETAS     = 180,
  parameter int          RHOS       = 1024,
  parameter int          THETA_BITS = 8,
  parameter int          RHO_BITS   = 10,
  parameter int          NUM_PEAKS  = 4,
  parameter logic [15:0] THRESHOLD  = 16'd32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  accum_empty,
  output logic                  accum_rd_en,
  input  logic [15:0]           accum_dout,
  input  logic                  peak_full,
  output logic                  peak_wr_en,
  output logic [RHO_BITS-1:0]   peak_rho,
  output logic [THETA_BITS-1:0] peak_theta,
  output logic [15:0]           peak_votes,
  output logic                  frame_done
);

  localparam int IDX_W = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;

  state_e                  state_r, state_next_s;
  logic [RHO_BITS-1:0]     rho_idx_r;
  logic [THETA_BITS-1:0]   theta_idx_r;
  logic [IDX_W-1:0]        emit_idx_r;
  logic                    last_word_s, next_valid_s, emit_last_s;
  logic [15:0]             rd_votes_s;
  logic [RHO_BITS-1:0]     rd_rho_s;
  logic [THETA_BITS-1:0]   rd_theta_s;
  logic                    rd_valid_s;
  logic [NUM_PEAKS-1:0]    valid_vec_s;

  hough_peak_table #(
    .NUM_PEAKS (NUM_PEAKS),
    .THRESHOLD (THRESHOLD),
    .RHO_BITS  (RHO_BITS),
    .THETA_BITS(THETA_BITS),
    .IDX_W     (IDX_W)
  ) u_table (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_r == DONE),
    .ins_en   (accum_rd_en),
    .ins_votes(accum_dout),
    .ins_rho  (rho_idx_r),
    .ins_theta(theta_idx_r),
    .rd_idx   (emit_idx_r),
    .rd_votes (rd_votes_s),
    .rd_rho   (rd_rho_s),
    .rd_theta (rd_theta_s),
    .rd_valid (rd_valid_s),
    .valid_vec(valid_vec_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= SCAN;
    else       state_r <= state_next_s;
  end

  // Next state and outputs; valid slots are contiguous, so emission ends once
  // the slot after the current one is empty or the table end is reached.
  always_comb begin
    state_next_s = state_r;
    accum_rd_en  = 1'b0;
    peak_wr_en   = 1'b0;
    frame_done   = 1'b0;
    last_word_s  = (rho_idx_r == RHO_BITS'(RHOS - 1)) && (theta_idx_r == THETA_BITS'(THETAS - 1));
    next_valid_s = |(valid_vec_s >> (32'(emit_idx_r) + 32'd1));
    emit_last_s  = (32'(emit_idx_r) == NUM_PEAKS - 1) || !next_valid_s;
    if (reset) begin
      peak_rho   = '0;
      peak_theta = '0;
      peak_votes = 16'd0;
    end else begin
      peak_rho   = rd_rho_s;
      peak_theta = rd_theta_s;
      peak_votes = rd_votes_s;
    end
    case (state_r)
      SCAN: begin
        accum_rd_en = !reset && !accum_empty;
        if (accum_rd_en && last_word_s) state_next_s = EMIT;
        else                            state_next_s = SCAN;
      end
      EMIT: begin
        peak_wr_en = !reset && !peak_full && rd_valid_s;
        if (!rd_valid_s)                     state_next_s = DONE;
        else if (peak_wr_en && emit_last_s)  state_next_s = DONE;
        else                                 state_next_s = EMIT;
      end
      DONE: begin
        frame_done   = !reset;
        state_next_s = SCAN;
      end
      default: state_next_s = SCAN;
    endcase
  end

  // Frame position and emission index counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      rho_idx_r   <= '0;
      theta_idx_r <= '0;
      emit_idx_r  <= '0;
    end else begin
      if (accum_rd_en) begin
        if (rho_idx_r == RHO_BITS'(RHOS - 1)) begin
          rho_idx_r   <= '0;
          theta_idx_r <= (theta_idx_r == THETA_BITS'(THETAS - 1)) ? '0 : theta_idx_r + THETA_BITS'(1);
        end else begin
          rho_idx_r <= rho_idx_r + RHO_BITS'(1);
        end
      end
      if (state_r == DONE)  emit_idx_r <= '0;
      else if (peak_wr_en)  emit_idx_r <= emit_idx_r + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_hough_peak_select.sv
// Directed bench for hough_peak_select on a 4x8 frame with a 2-entry table.
module tb_hough_peak_select;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        accum_empty = 1'b1;
  logic        accum_rd_en;
  logic [15:0] accum_dout = 16'd0;
  logic        peak_full = 1'b0;
  logic        peak_wr_en;
  logic [2:0]  peak_rho;
  logic [1:0]  peak_theta;
  logic [15:0] peak_votes;
  logic        frame_done;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int done_gap = 0;
  int done_cnt = 0;
  logic [31:0] wr_q[$];
  logic [15:0] frame_mem [32];

  hough_peak_select #(
    .THETAS(4), .RHOS(8), .THETA_BITS(2), .RHO_BITS(3),
    .NUM_PEAKS(2), .THRESHOLD(16'd3)
  ) dut (
    .clock(clock), .reset(reset), .accum_empty(accum_empty), .accum_rd_en(accum_rd_en),
    .accum_dout(accum_dout), .peak_full(peak_full), .peak_wr_en(peak_wr_en),
    .peak_rho(peak_rho), .peak_theta(peak_theta), .peak_votes(peak_votes),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Observe settled outputs mid-cycle.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (accum_rd_en) last_acc_cyc <= cyc;
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_gap <= cyc - last_acc_cyc;
    end
    if (peak_wr_en) wr_q.push_back({peak_votes, 6'd0, peak_theta, 5'd0, peak_rho});
  end

  task automatic clear_frame();
    for (int i = 0; i < 32; i++) frame_mem[i] = 16'd0;
    wr_q.delete();
  endtask

  // Feed n words starting at posedge+1; gap toggles accum_empty every cycle.
  task automatic feed(input int n, input bit gap);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b0;
    bit took;
    while (idx < n && guard < 1000) begin
      accum_empty = gap ? ph : 1'b0;
      ph = ~ph;
      accum_dout = frame_mem[idx];
      @(negedge clock);
      took = accum_rd_en;
      @(posedge clock); #1;
      if (took) idx++;
      guard++;
    end
    accum_empty = 1'b1;
    accum_dout = 16'd0;
    tests_run++;
    if (idx !== n) begin
      tests_failed++;
      $display("FAIL feed_accepts got=%0d exp=%0d", idx, n);
    end
  endtask

  task automatic wait_done(input int start);
    for (int c = 0; c < 20 && done_cnt == start; c++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (done_cnt !== start + 1) begin
      tests_failed++;
      $display("FAIL frame_done_count got=%0d exp=%0d", done_cnt - start, 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; accum_empty = 1'b0; accum_dout = 16'd50;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if ({accum_rd_en, peak_wr_en, frame_done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got=%b exp=000", {accum_rd_en, peak_wr_en, frame_done});
    end
    tests_run++;
    if ({peak_votes, peak_theta, peak_rho} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_data got=%h exp=0", {peak_votes, peak_theta, peak_rho});
    end
    @(posedge clock); #1;
    reset = 1'b0; accum_empty = 1'b1; accum_dout = 16'd0;
    @(negedge clock);
    tests_run++;
    if ({peak_wr_en, frame_done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL post_reset got=%b exp=00", {peak_wr_en, frame_done});
    end
    @(posedge clock); #1;
  endtask

  task automatic test_all_zero();
    int start = done_cnt;
    int rd_seen = 0;
    clear_frame();
    feed(32, 1'b0);
    accum_empty = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (accum_rd_en) rd_seen++;
      if (frame_done) break;
    end
    accum_empty = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (rd_seen !== 0) begin
      tests_failed++;
      $display("FAIL rd_en_in_emit_done got=%0d exp=0", rd_seen);
    end
    wait_done(start);
    tests_run++;
    if (done_gap !== 2) begin
      tests_failed++;
      $display("FAIL done_latency got=%0d exp=2", done_gap);
    end
    tests_run++;
    if (wr_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL zero_frame_writes got=%0d exp=0", wr_q.size());
    end
  endtask

  task automatic test_single_peak();
    int start = done_cnt;
    clear_frame();
    frame_mem[2*8+5] = 16'd10;
    feed(32, 1'b0);
    wait_done(start);
    tests_run++;
    if (wr_q.size() !== 1 || wr_q[0] !== {16'd10, 8'd2, 8'd5}) begin
      tests_failed++;
      $display("FAIL single_peak got=n%0d/%h exp=n1/%h", wr_q.size(), wr_q[0], {16'd10, 8'd2, 8'd5});
    end
  endtask

  task automatic test_sorted_top2();
    int start = done_cnt;
    clear_frame();
    frame_mem[0*8+1] = 16'd5;
    frame_mem[1*8+3] = 16'd9;
    frame_mem[3*8+7] = 16'd7;
    frame_mem[2*8+2] = 16'd2;
    feed(32, 1'b0);
    wait_done(start);
    tests_run++;
    if (wr_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL top2_count got=%0d exp=2", wr_q.size());
    end
    tests_run++;
    if (wr_q[0] !== {16'd9, 8'd1, 8'd3} || wr_q[1] !== {16'd7, 8'd3, 8'd7}) begin
      tests_failed++;
      $display("FAIL top2_order got=%h,%h exp=%h,%h", wr_q[0], wr_q[1], {16'd9, 8'd1, 8'd3}, {16'd7, 8'd3, 8'd7});
    end
  endtask

  task automatic load_ties();
    clear_frame();
    frame_mem[0]       = 16'd6;
    frame_mem[2*8+4]   = 16'd6;
    frame_mem[3*8+0]   = 16'd6;
  endtask

  task automatic test_ties();
    int start = done_cnt;
    load_ties();
    feed(32, 1'b0);
    wait_done(start);
    tests_run++;
    if (wr_q.size() !== 2 || wr_q[0] !== {16'd6, 8'd0, 8'd0} || wr_q[1] !== {16'd6, 8'd2, 8'd4}) begin
      tests_failed++;
      $display("FAIL ties got=n%0d %h,%h exp=n2 %h,%h", wr_q.size(), wr_q[0], wr_q[1], {16'd6, 8'd0, 8'd0}, {16'd6, 8'd2, 8'd4});
    end
  endtask

  task automatic test_back_pressure();
    int start = done_cnt;
    int bad = 0;
    clear_frame();
    frame_mem[0*8+1] = 16'd5;
    frame_mem[1*8+3] = 16'd9;
    frame_mem[3*8+7] = 16'd7;
    peak_full = 1'b1;
    feed(32, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (peak_wr_en !== 1'b0 || {peak_votes, peak_theta, peak_rho} !== {16'd9, 2'd1, 3'd3}) bad++;
    end
    @(posedge clock); #1;
    peak_full = 1'b0;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL full_hold got=%0d_bad_cycles exp=0", bad);
    end
    wait_done(start);
    tests_run++;
    if (wr_q.size() !== 2 || wr_q[0] !== {16'd9, 8'd1, 8'd3} || wr_q[1] !== {16'd7, 8'd3, 8'd7}) begin
      tests_failed++;
      $display("FAIL full_release got=n%0d %h,%h exp=n2 %h,%h", wr_q.size(), wr_q[0], wr_q[1], {16'd9, 8'd1, 8'd3}, {16'd7, 8'd3, 8'd7});
    end
  endtask

  task automatic test_gapped_reset();
    int start;
    clear_frame();
    frame_mem[0*8+1] = 16'd5;
    frame_mem[1*8+3] = 16'd9;
    feed(13, 1'b1);
    reset = 1'b1; accum_empty = 1'b0; accum_dout = 16'd40;
    @(negedge clock);
    tests_run++;
    if ({accum_rd_en, peak_wr_en, frame_done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midframe_reset_ctrl got=%b exp=000", {accum_rd_en, peak_wr_en, frame_done});
    end
    @(posedge clock); #1;
    reset = 1'b0; accum_empty = 1'b1; accum_dout = 16'd0;
    start = done_cnt;
    load_ties();
    feed(32, 1'b1);
    wait_done(start);
    tests_run++;
    if (wr_q.size() !== 2 || wr_q[0] !== {16'd6, 8'd0, 8'd0} || wr_q[1] !== {16'd6, 8'd2, 8'd4}) begin
      tests_failed++;
      $display("FAIL restart_index got=n%0d %h,%h exp=n2 %h,%h", wr_q.size(), wr_q[0], wr_q[1], {16'd6, 8'd0, 8'd0}, {16'd6, 8'd2, 8'd4});
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_peak();
    test_sorted_top2();
    test_ties();
    test_back_pressure();
    test_gapped_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
